// File: rtl/shift_serializer_if.sv
// Parallel-in / serial-out handshake bundle for shift_serializer.
// slave = serializer side, master = producer/consumer side.
interface shift_serializer_if #(
  parameter int n = 16
);
  logic [n-1:0] data_in;
  logic         in_valid;
  logic         in_ready;
  logic         dir;
  logic         ser_out;
  logic         ser_valid;
  logic         ser_ready;
  logic         done;

  modport master (
    output data_in, in_valid, dir, ser_ready,
    input  in_ready, ser_out, ser_valid, done
  );

  modport slave (
    input  data_in, in_valid, dir, ser_ready,
    output in_ready, ser_out, ser_valid, done
  );
endinterface

// File: rtl/shift_serializer.sv
// Word-to-bitstream serializer with valid/ready on both sides.
// Optional even-parity trailer bit when SER_PARITY_EN is defined.
module shift_serializer #(
  parameter int n = 16
) (
  input logic               clk,
  input logic               reset,
  shift_serializer_if.slave bus
);

  localparam int CW = $clog2(n + 1);

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } state_t;
`endif

  state_t        state, state_n;
  logic [n-1:0]  word, word_n;
  logic          dir_q, dir_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          out_q, out_n;
  logic          vld_q, vld_n;
  logic          done_q, done_n;

  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] idx;
  logic [n-1:0]  mask;
  logic          nxt_bit;
  logic          last;
  logic          xfer;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      word   <= '0;
      dir_q  <= 1'b0;
      cnt    <= '0;
      out_q  <= 1'b0;
      vld_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      word   <= word_n;
      dir_q  <= dir_n;
      cnt    <= cnt_n;
      out_q  <= out_n;
      vld_q  <= vld_n;
      done_q <= done_n;
    end
  end

  // Next bit index follows the captured direction.
  always_comb begin
    cnt_inc = cnt + CW'(1);
    idx     = dir_q ? cnt_inc : (CW'(n - 1) - cnt_inc);
    mask    = {{(n-1){1'b0}}, 1'b1} << idx;
    nxt_bit = |(word & mask);
    last    = (cnt == CW'(n - 1));
    xfer    = vld_q & bus.ser_ready;
  end

  always_comb begin
    state_n = state;
    word_n  = word;
    dir_n   = dir_q;
    cnt_n   = cnt;
    out_n   = out_q;
    vld_n   = vld_q;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        vld_n = 1'b0;
        out_n = 1'b0;
        if (bus.in_valid) begin
          state_n = SHIFT;
          word_n  = bus.data_in;
          dir_n   = bus.dir;
          cnt_n   = '0;
          vld_n   = 1'b1;
          out_n   = bus.dir ? bus.data_in[0]
                            : bus.data_in[n-1];
        end
      end
      SHIFT: begin
        if (xfer) begin
          if (last) begin
            cnt_n = '0;
`ifdef SER_PARITY_EN
            state_n = PARITY;
            out_n   = ^word;
`else
            state_n = IDLE;
            vld_n   = 1'b0;
            out_n   = 1'b0;
            done_n  = 1'b1;
`endif
          end else begin
            cnt_n = cnt_inc;
            out_n = nxt_bit;
          end
        end
      end
`ifdef SER_PARITY_EN
      PARITY: begin
        if (xfer) begin
          state_n = IDLE;
          vld_n   = 1'b0;
          out_n   = 1'b0;
          done_n  = 1'b1;
        end
      end
`endif
      default: begin
        state_n = IDLE;
        vld_n   = 1'b0;
        out_n   = 1'b0;
      end
    endcase
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.ser_out   = out_q;
  assign bus.ser_valid = vld_q;
  assign bus.done      = done_q;

endmodule

// File: doc/shift_serializer.md
SHIFT_SERIALIZER -- requirements
Module: shift_serializer

Interface
REQ-001 The block SHALL have parameter n, default 16, giving the parallel word width (n >= 2).
REQ-002 The block SHALL have the port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have the port data_in, input, n bits: the parallel word from the upstream universal shift register's data_out.
REQ-005 The block SHALL have the port in_valid, input, 1 bit: data_in is valid.
REQ-006 The block SHALL have the port in_ready, output, 1 bit: the block can accept a word.
REQ-007 The block SHALL have the port dir, input, 1 bit: 0 = MSB-first, 1 = LSB-first; sampled only at accept.
REQ-008 The block SHALL have the port ser_out, output, 1 bit: the current serial bit.
REQ-009 The block SHALL have the port ser_valid, output, 1 bit: ser_out is valid.
REQ-010 The block SHALL have the port ser_ready, input, 1 bit: the consumer takes ser_out this cycle.
REQ-011 The block SHALL have the port done, output, 1 bit: a one-cycle pulse marking the end of a word.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT and PARITY, where PARITY exists only with SER_PARITY_EN.
REQ-013 in_ready SHALL be 1 in IDLE and 0 in every other state.
REQ-014 A word SHALL be accepted on a rising edge where in_valid && in_ready; data_in and dir are captured into internal registers.
REQ-015 On accept, the FSM SHALL go to SHIFT; ser_valid = 1 and ser_out = first bit (data_in[n-1] if dir = 0, data_in[0] if dir = 1) from the following cycle.
REQ-016 In SHIFT, a bit transfer SHALL occur on each edge with ser_valid && ser_ready; the next bit is then presented and the bit counter increments.
REQ-017 While ser_ready = 0, ser_out, ser_valid and the counter SHALL hold.
REQ-018 The bit counter SHALL be $clog2(n+1) bits wide, count 0..n-1, and never wrap within a word.
REQ-019 On the transfer of bit n-1 without parity, the FSM SHALL go to IDLE: ser_valid = 0, in_ready = 1 and done = 1 for exactly the next cycle.
REQ-020 in_valid SHALL be ignored outside IDLE; there is one idle cycle between words.
REQ-021 ser_out SHALL be 0 whenever ser_valid = 0.
REQ-022 Serial outputs (ser_out, ser_valid, done) SHALL be registered, with no combinational path from ser_ready or in_valid.

Reset
REQ-023 When reset = 1 at a rising edge, the block SHALL go to IDLE: ser_out = 0, ser_valid = 0, done = 0, counter = 0, captured word = 0, in_ready = 1 next cycle.
REQ-024 A reset mid-word SHALL discard the word and produce no done pulse.
REQ-025 reset SHALL take priority over simultaneous in_valid or ser_ready.

Configuration
REQ-026 With macro SER_PARITY_EN defined, after bit n-1 transfers the FSM SHALL enter PARITY and present the even-parity bit (XOR of the captured word) with ser_valid = 1 and ser_ready honoured as in SHIFT.
REQ-027 With SER_PARITY_EN defined, done SHALL pulse the cycle after the parity bit transfers, giving n+1 serial bits per word.
REQ-028 Without SER_PARITY_EN, the PARITY state and logic SHALL be absent, giving n serial bits per word.

Verification (n = 16)
REQ-029 Accept 0xA5C3, dir = 0, ser_ready = 1 -> ser_out 1010010111000011 on 16 consecutive cycles, then done = 1 for 1 cycle, then in_ready = 1.
REQ-030 Accept 0x0001, dir = 1 -> first bit 1, then 15 zeros; done after 16 transfers.
REQ-031 Drop ser_ready to 0 for 3 cycles after the 5th transfer -> ser_out and ser_valid held; word completes in 19 cycles with bits unchanged.
REQ-032 Assert in_valid with 0xFFFF while in SHIFT -> in_ready = 0, no capture, and the current word is unaffected.
REQ-033 Assert reset after the 7th transfer -> ser_valid = 0, done = 0 and in_ready = 1 the next cycle; the next word starts from bit 0.
REQ-034 With SER_PARITY_EN, accept 0x0007, dir = 0 -> 16 data bits then 1 parity bit = 1 as the 17th bit; done after the 17th transfer.
